// File: rtl/rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue
//
// Write-side producer for the 32x32 integer register file. Results that
// retire from the load unit and from the execute pipe are accepted one per
// cycle and kept in an in-order FIFO. The FIFO drains one entry per cycle
// into the register file write port.
//
// Optional feature macro: WBQ_FWD_EN
//   defined   : operand readers (rs1/rs2) can look up the youngest pending
//               value for a register that has not been written yet.
//   undefined : the lookup logic is not built; fwd_*_hit and fwd_*_data
//               are tied to 0.
//
// Ports
//   clk, rst                 rising-edge clock; asynchronous active-low reset
//   ld_valid/ld_ready        load result handshake, with ld_rd / ld_data
//   ex_valid/ex_ready        execute result handshake, with ex_rd / ex_data
//   wb_hold                  register file port busy; stops the drain
//   rf_en/rf_rd/rf_data      register file write port (head of the FIFO)
//   rs1, rs2                 operand indices for the forwarding lookup
//   fwd_a_hit/fwd_a_data     pending value for rs1
//   fwd_b_hit/fwd_b_data     pending value for rs2
//   wbq_count                number of occupied entries (registered)
//
// Handshake: a producer holds valid and its payload stable; a transfer happens
// on the rising edge where valid && ready are both 1. ready never depends on
// the same cycle's pop, so a full queue refuses input even while it drains.
// The load unit has fixed priority: ex_ready is 0 whenever ld_valid is 1.
// Results for x0 (rd == 0) complete the handshake but are dropped.
// ---------------------------------------------------------------------------
module rf_writeback_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic [4:0]                 ex_rd,
  input  logic [XLEN-1:0]            ex_data,
  input  logic                       wb_hold,
  output logic                       rf_en,
  output logic [4:0]                 rf_rd,
  output logic [XLEN-1:0]            rf_data,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  output logic                       fwd_a_hit,
  output logic [XLEN-1:0]            fwd_a_data,
  output logic                       fwd_b_hit,
  output logic [XLEN-1:0]            fwd_b_data,
  output logic [$clog2(DEPTH+1)-1:0] wbq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q [DEPTH];
  logic            valid_d [DEPTH];
  logic [4:0]      rd_q    [DEPTH];
  logic [4:0]      rd_d    [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];
  logic [XLEN-1:0] data_d  [DEPTH];

  // -------------------------------------------------------------------------
  // Input arbitration and push selection
  // -------------------------------------------------------------------------
  logic            full;
  logic            ld_fire;
  logic            ex_fire;
  logic            push;
  logic            pop;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;
  logic            head_valid;

  always_comb begin
    // Fullness is judged on the registered count, before any pop this cycle.
    full      = (count_q == DEPTH_C);
    ld_ready  = rst && !full;
    ex_ready  = rst && !full && !ld_valid;
    ld_fire   = ld_valid && ld_ready;
    ex_fire   = ex_valid && ex_ready;

    push_rd   = ex_rd;
    push_data = ex_data;
    if (ld_fire) begin
      push_rd   = ld_rd;
      push_data = ld_data;
    end

    // An accepted x0 result is consumed here and never reaches storage.
    push = (ld_fire && (ld_rd != 5'd0)) || (ex_fire && (ex_rd != 5'd0));
  end

  // -------------------------------------------------------------------------
  // Drain port: head entry straight from storage
  // -------------------------------------------------------------------------
  always_comb begin
    // The head valid bit is set exactly when the queue is non-empty; checking
    // both keeps a stale slot from ever reaching the register file.
    head_valid = valid_q[head_q];
    rf_en      = (count_q != '0) && head_valid && !wb_hold;
    rf_rd      = rd_q[head_q];
    rf_data    = data_q[head_q];
    pop        = rf_en;
  end

  assign wbq_count = count_q;

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;

    // Push and pop never address the same slot: a pop needs a non-empty
    // queue and a push needs a non-full one, so head != tail when both fire.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      rd_d[tail_q]    = push_rd;
      data_d[tail_q]  = push_data;
      tail_d          = tail_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding lookup
  // -------------------------------------------------------------------------
`ifdef WBQ_FWD_EN
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    // Walk from oldest (head) to youngest; a later match overrides an
    // earlier one, so the result is the value closest to the tail.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (rs1 != 5'd0) && (rd_q[idx] == rs1)) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = data_q[idx];
      end
      if (valid_q[idx] && (rs2 != 5'd0) && (rd_q[idx] == rs2)) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = data_q[idx];
      end
    end
  end
`else
  logic unused_rs;
  assign unused_rs  = ^{rs1, rs2};
  assign fwd_a_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_queue
//
// Directed scenarios followed by randomized traffic. The reference model is
// a queue of pending {rd, data} writes: accepted non-x0 results are appended,
// every register file write removes the front. All expected port values are
// derived from that queue's size and contents.
// ---------------------------------------------------------------------------
module tb_rf_writeback_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int W     = XLEN + 5;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // -------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst;
  logic            ld_valid, ex_valid, wb_hold;
  logic [4:0]      ld_rd, ex_rd, rs1, rs2;
  logic [XLEN-1:0] ld_data, ex_data;
  logic            ld_ready, ex_ready, rf_en;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            fwd_a_hit, fwd_b_hit;
  logic [XLEN-1:0] fwd_a_data, fwd_b_data;
  logic [CW-1:0]   wbq_count;

  always #5 clk = ~clk;

  rf_writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .wb_hold    (wb_hold),
    .rf_en      (rf_en),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_b_data (fwd_b_data),
    .wbq_count  (wbq_count)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Youngest pending value for rs, from the model queue.
  function automatic void fwd_model(input logic [4:0] rs, output logic hit,
                                    output logic [XLEN-1:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef WBQ_FWD_EN
    if (rs != 5'd0)
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i][W-1:XLEN] == rs) begin
          hit  = 1'b1;
          data = exp_q[i][XLEN-1:0];
        end
`endif
  endfunction

  // Monitor: inputs change only just after the rising edge, so the negedge
  // view is what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_ld_ready", 64'(ld_ready), 64'd0);
      check("rst_ex_ready", 64'(ex_ready), 64'd0);
      check("rst_rf_en", 64'(rf_en), 64'd0);
      check("rst_count", 64'(wbq_count), 64'd0);
      check("rst_fwd_a_hit", 64'(fwd_a_hit), 64'd0);
      check("rst_fwd_b_hit", 64'(fwd_b_hit), 64'd0);
      exp_q.delete();
    end else begin
      int sz;
      logic e_en, ha, hb;
      logic [XLEN-1:0] da, db;
      sz   = exp_q.size();
      e_en = (sz != 0) && !wb_hold;
      check("ld_ready", 64'(ld_ready), 64'(sz < DEPTH));
      check("ex_ready", 64'(ex_ready), 64'((sz < DEPTH) && !ld_valid));
      check("count", 64'(wbq_count), 64'(sz));
      check("rf_en", 64'(rf_en), 64'(e_en));
      if (e_en && rf_en) begin
        check("rf_rd", 64'(rf_rd), 64'(exp_q[0][W-1:XLEN]));
        check("rf_data", 64'(rf_data), 64'(exp_q[0][XLEN-1:0]));
      end
      fwd_model(rs1, ha, da);
      fwd_model(rs2, hb, db);
      check("fwd_a_hit", 64'(fwd_a_hit), 64'(ha));
      check("fwd_b_hit", 64'(fwd_b_hit), 64'(hb));
`ifdef WBQ_FWD_EN
      if (ha) check("fwd_a_data", 64'(fwd_a_data), 64'(da));
      if (hb) check("fwd_b_data", 64'(fwd_b_data), 64'(db));
`else
      check("fwd_a_data", 64'(fwd_a_data), 64'd0);
      check("fwd_b_data", 64'(fwd_b_data), 64'd0);
`endif
      // Model update for the coming edge: pop the front, then append the
      // accepted result (acceptance judged on the pre-pop size).
      if (e_en) void'(exp_q.pop_front());
      if (ld_valid && sz < DEPTH) begin
        if (ld_rd != 5'd0) exp_q.push_back({ld_rd, ld_data});
      end else if (ex_valid && sz < DEPTH) begin
        if (ex_rd != 5'd0) exp_q.push_back({ex_rd, ex_data});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 1'b0;
    ex_valid = 1'b0;
  endtask

  // Keep the presented ex result until it is taken, bounded by a cycle budget.
  task automatic hold_ex_until_taken(input int bound);
    bit taken = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (ex_valid && ex_ready) begin
        taken = 1'b1;
        break;
      end
    end
    check("ex_taken_within_bound", 64'(taken), 64'd1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic send_ex(input logic [4:0] rd, input logic [XLEN-1:0] data, input int bound);
    ex_valid = 1'b1;
    ex_rd    = rd;
    ex_data  = data;
    hold_ex_until_taken(bound);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
    wb_hold = 1'b0; rs1 = '0; rs2 = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Single execute result, drains the next cycle.
    send_ex(5'd5, 32'hDEADBEEF, 3);
    repeat (2) step();

    // Load and execute in the same cycle: load first, execute next.
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'h22;
    step();
    ld_valid = 1'b0;
    hold_ex_until_taken(3);
    repeat (3) step();

    // Fill under hold, fifth stalls, release and drain with pointer wrap.
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) send_ex(5'(10 + i), $urandom, 3);
    ex_valid = 1'b1; ex_rd = 5'd14; ex_data = 32'h5555_0005;
    repeat (2) step();
    check("full_ex_ready", 64'(ex_ready), 64'd0);
    check("full_count", 64'(wbq_count), 64'(DEPTH));
    wb_hold = 1'b0;
    hold_ex_until_taken(4);
    repeat (6) step();

    // Result for x0 is accepted and dropped.
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1234; rs1 = 5'd0;
    step();
    ld_valid = 1'b0;
    repeat (2) step();

    // Forwarding: youngest of two writes to x7.
    wb_hold = 1'b1;
    send_ex(5'd7, 32'hA, 3);
    send_ex(5'd7, 32'hB, 3);
    rs1 = 5'd7; rs2 = 5'd8;
    step();
    rs1 = 5'd0;
    step();
    wb_hold = 1'b0;
    repeat (5) step();

    // Asynchronous reset in the middle of a drain.
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) send_ex(5'(20 + i), $urandom, 3);
    wb_hold = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", 64'(wbq_count), 64'd0);
    check("async_rst_rf_en", 64'(rf_en), 64'd0);
    check("async_rst_ld_ready", 64'(ld_ready), 64'd0);
    step();
    #2 rst = 1'b1;
    repeat (4) step();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_rd    = 5'($urandom_range(0, 7));
      ld_data  = $urandom;
      ex_valid = ($urandom_range(0, 1) == 0);
      ex_rd    = 5'($urandom_range(0, 7));
      ex_data  = $urandom;
      wb_hold  = ($urandom_range(0, 3) == 0);
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      step();
    end

    // Drain whatever remains, bounded.
    idle();
    wb_hold = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    check("final_drain_empty", 64'(exp_q.size()), 64'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
